// File: rtl/decode_pipe.sv
// decode_pipe: pipelined decode stage.
// Holds the architectural register file and extends the immediate.
// Results go into an ID/EX register with valid/stall/flush control.
// A writeback-to-decode bypass is included, and source operands are
// refreshed while the entry is stalled, so a held instruction never
// carries stale data into execute.
module decode_pipe #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter bit BYPASS   = 1'b1,
  localparam int REG_BITS = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         InstrIn,
  input  logic                InstrValid,
  input  logic [WIDTH-1:0]    PcIn,
  input  logic                RegWriteIn,
  input  logic [1:0]          DstSel,
  input  logic [2:0]          ImmFmt,
  input  logic                WbWrite,
  input  logic [REG_BITS-1:0] WbReg,
  input  logic [WIDTH-1:0]    WbData,
  input  logic                Stall,
  input  logic                Flush,
  output logic                ValidOut,
  output logic [WIDTH-1:0]    Op1,
  output logic [WIDTH-1:0]    Op2,
  output logic [WIDTH-1:0]    ImmOut,
  output logic [REG_BITS-1:0] DstRegOut,
  output logic                RegWriteOut,
  output logic [WIDTH-1:0]    PcOut,
  output logic                Err
);

  // The immediate is built at least 16 bits wide.
  // Sign extension therefore reaches the full datapath when WIDTH > 16.
  // The result is truncated when WIDTH < 16.
  localparam int EXT = (WIDTH > 16) ? WIDTH : 16;

  // Architectural register file; there is no hardwired-zero entry.
  logic [WIDTH-1:0] regs_q [NUM_REGS];

  // Decode-side combinational results.
  logic [REG_BITS-1:0] rsSel;
  logic [REG_BITS-1:0] rtSel;
  logic [REG_BITS-1:0] dstDec;
  logic [WIDTH-1:0]    op1Dec;
  logic [WIDTH-1:0]    op2Dec;
  logic [EXT-1:0]      immWide;
  logic [WIDTH-1:0]    immDec;
  logic                fmtIllegal;

  // ID/EX pipeline register and its next state.
  logic                valid_q,    valid_d;
  logic [WIDTH-1:0]    op1_q,      op1_d;
  logic [WIDTH-1:0]    op2_q,      op2_d;
  logic [WIDTH-1:0]    imm_q,      imm_d;
  logic [REG_BITS-1:0] dst_q,      dst_d;
  logic                regWrite_q, regWrite_d;
  logic [WIDTH-1:0]    pc_q,       pc_d;
  logic [REG_BITS-1:0] srcA_q,     srcA_d;
  logic [REG_BITS-1:0] srcB_q,     srcB_d;
  logic                err_q,      err_d;

  // The opcode bits are decoded by the control unit, not by this stage.
  logic unusedOpcode;
  assign unusedOpcode = ^InstrIn[15:11];

  // Register fields are zero-extended to the register-select width.
  assign rsSel = REG_BITS'(InstrIn[10:8]);
  assign rtSel = REG_BITS'(InstrIn[7:5]);

  // Register file write port; reset clears every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WbWrite) begin
      regs_q[WbReg] <= WbData;
    end
  end

  // Operand read, with a same-cycle writeback bypass per operand.
  always_comb begin
    op1Dec = regs_q[rsSel];
    op2Dec = regs_q[rtSel];
    if (BYPASS && WbWrite && (WbReg == rsSel)) begin
      op1Dec = WbData;
    end
    if (BYPASS && WbWrite && (WbReg == rtSel)) begin
      op2Dec = WbData;
    end
  end

  // Immediate extension from the control-unit format select.
  always_comb begin
    immWide    = '0;
    fmtIllegal = 1'b0;
    case (ImmFmt)
      3'd0: immWide = '0;
      3'd1: immWide = {{(EXT-5){1'b0}}, InstrIn[4:0]};
      3'd2: immWide = {{(EXT-5){InstrIn[4]}}, InstrIn[4:0]};
      3'd3: immWide = {{(EXT-8){1'b0}}, InstrIn[7:0]};
      3'd4: immWide = {{(EXT-8){InstrIn[7]}}, InstrIn[7:0]};
      3'd5: immWide = {{(EXT-11){InstrIn[10]}}, InstrIn[10:0]};
      default: begin
        immWide    = '0;
        fmtIllegal = 1'b1;
      end
    endcase
  end

  assign immDec = immWide[WIDTH-1:0];

  // Destination register resolution; select 3 is the link register r7.
  always_comb begin
    dstDec = rsSel;
    case (DstSel)
      2'd0: dstDec = rsSel;
      2'd1: dstDec = rtSel;
      2'd2: dstDec = REG_BITS'(InstrIn[4:2]);
      2'd3: dstDec = REG_BITS'(3'd7);
      default: dstDec = rsSel;
    endcase
  end

  // ID/EX next state: flush beats stall, stall holds (with operand refresh), else capture.
  always_comb begin
    valid_d    = valid_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    imm_d      = imm_q;
    dst_d      = dst_q;
    regWrite_d = regWrite_q;
    pc_d       = pc_q;
    srcA_d     = srcA_q;
    srcB_d     = srcB_q;
    err_d      = err_q;
    if (Flush) begin
      valid_d    = 1'b0;
      regWrite_d = 1'b0;
    end else if (Stall) begin
      if (BYPASS && WbWrite && (WbReg == srcA_q)) begin
        op1_d = WbData;
      end
      if (BYPASS && WbWrite && (WbReg == srcB_q)) begin
        op2_d = WbData;
      end
    end else begin
      valid_d    = InstrValid;
      op1_d      = op1Dec;
      op2_d      = op2Dec;
      imm_d      = immDec;
      dst_d      = dstDec;
      regWrite_d = RegWriteIn & InstrValid;
      pc_d       = PcIn;
      srcA_d     = rsSel;
      srcB_d     = rtSel;
      err_d      = err_q | (InstrValid & fmtIllegal);
    end
  end

  // ID/EX register update, with reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      imm_q      <= '0;
      dst_q      <= '0;
      regWrite_q <= 1'b0;
      pc_q       <= '0;
      srcA_q     <= '0;
      srcB_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      imm_q      <= imm_d;
      dst_q      <= dst_d;
      regWrite_q <= regWrite_d;
      pc_q       <= pc_d;
      srcA_q     <= srcA_d;
      srcB_q     <= srcB_d;
      err_q      <= err_d;
    end
  end

  assign ValidOut    = valid_q;
  assign Op1         = op1_q;
  assign Op2         = op2_q;
  assign ImmOut      = imm_q;
  assign DstRegOut   = dst_q;
  assign RegWriteOut = regWrite_q;
  assign PcOut       = pc_q;
  assign Err         = err_q;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed checks of decode_pipe.
// Two instances share the same inputs: one with the bypass enabled and one without.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instrIn;
  logic        instrValid;
  logic [15:0] pcIn;
  logic        regWriteIn;
  logic [1:0]  dstSel;
  logic [2:0]  immFmt;
  logic        wbWrite;
  logic [2:0]  wbReg;
  logic [15:0] wbData;
  logic        stall;
  logic        flush;

  logic        valid1, rw1, err1;
  logic [15:0] opA1, opB1, imm1, pc1;
  logic [2:0]  dst1;
  logic        valid0, rw0, err0;
  logic [15:0] opA0, opB0, imm0, pc0;
  logic [2:0]  dst0;

  int passCount = 0;
  int totalCount = 0;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  fmt;
    logic        valid;
    logic [1:0]  dSel;
    logic        regWr;
    logic [15:0] pc;
    logic [15:0] expImm;
    logic [2:0]  expDst;
    logic        expRw;
  } vec_t;

  vec_t vecs[15];

  decode_pipe #(.WIDTH(16), .NUM_REGS(8), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .InstrIn(instrIn), .InstrValid(instrValid),
    .PcIn(pcIn), .RegWriteIn(regWriteIn), .DstSel(dstSel), .ImmFmt(immFmt),
    .WbWrite(wbWrite), .WbReg(wbReg), .WbData(wbData), .Stall(stall),
    .Flush(flush), .ValidOut(valid1), .Op1(opA1), .Op2(opB1), .ImmOut(imm1),
    .DstRegOut(dst1), .RegWriteOut(rw1), .PcOut(pc1), .Err(err1)
  );

  decode_pipe #(.WIDTH(16), .NUM_REGS(8), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .InstrIn(instrIn), .InstrValid(instrValid),
    .PcIn(pcIn), .RegWriteIn(regWriteIn), .DstSel(dstSel), .ImmFmt(immFmt),
    .WbWrite(wbWrite), .WbReg(wbReg), .WbData(wbData), .Stall(stall),
    .Flush(flush), .ValidOut(valid0), .Op1(opA0), .Op2(opB0), .ImmOut(imm0),
    .DstRegOut(dst0), .RegWriteOut(rw0), .PcOut(pc0), .Err(err0)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Advance one active edge, then settle so outputs are sampled away from it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  // The stalled entry captured with Rt = 5 must keep every field except Op2.
  task automatic checkHeld(input int cyc, input logic [15:0] expB1, input logic [15:0] expB0);
    checkOutput($sformatf("stall%0d_valid", cyc), 32'(valid1), 32'd1);
    checkOutput($sformatf("stall%0d_imm", cyc), 32'(imm1), 32'h00A0);
    checkOutput($sformatf("stall%0d_dst", cyc), 32'(dst1), 32'd5);
    checkOutput($sformatf("stall%0d_rw", cyc), 32'(rw1), 32'd1);
    checkOutput($sformatf("stall%0d_pc", cyc), 32'(pc1), 32'h0200);
    checkOutput($sformatf("stall%0d_op1", cyc), 32'(opA1), 32'h0000);
    checkOutput($sformatf("stall%0d_op2_byp", cyc), 32'(opB1), 32'(expB1));
    checkOutput($sformatf("stall%0d_op2_nobyp", cyc), 32'(opB0), 32'(expB0));
  endtask

  initial begin
    // Immediate formats on 0xF8F0, a negative 11-bit field, then the DstSel sweep on 0x0ABC.
    vecs[0]  = '{16'hF8F0, 3'd0, 1'b1, 2'd0, 1'b0, 16'h0100, 16'h0000, 3'd0, 1'b0};
    vecs[1]  = '{16'hF8F0, 3'd1, 1'b1, 2'd0, 1'b0, 16'h0102, 16'h0010, 3'd0, 1'b0};
    vecs[2]  = '{16'hF8F0, 3'd2, 1'b1, 2'd0, 1'b0, 16'h0104, 16'hFFF0, 3'd0, 1'b0};
    vecs[3]  = '{16'hF8F0, 3'd3, 1'b1, 2'd0, 1'b0, 16'h0106, 16'h00F0, 3'd0, 1'b0};
    vecs[4]  = '{16'hF8F0, 3'd4, 1'b1, 2'd0, 1'b0, 16'h0108, 16'hFFF0, 3'd0, 1'b0};
    vecs[5]  = '{16'hF8F0, 3'd5, 1'b1, 2'd0, 1'b0, 16'h010A, 16'h00F0, 3'd0, 1'b0};
    vecs[6]  = '{16'h0400, 3'd5, 1'b1, 2'd0, 1'b0, 16'h010C, 16'hFC00, 3'd4, 1'b0};
    vecs[7]  = '{16'h0ABC, 3'd3, 1'b1, 2'd0, 1'b1, 16'h0110, 16'h00BC, 3'd2, 1'b1};
    vecs[8]  = '{16'h0ABC, 3'd3, 1'b1, 2'd1, 1'b1, 16'h0112, 16'h00BC, 3'd5, 1'b1};
    vecs[9]  = '{16'h0ABC, 3'd3, 1'b1, 2'd2, 1'b1, 16'h0114, 16'h00BC, 3'd7, 1'b1};
    vecs[10] = '{16'h0ABC, 3'd3, 1'b1, 2'd3, 1'b1, 16'h0116, 16'h00BC, 3'd7, 1'b1};
    vecs[11] = '{16'h0ABC, 3'd3, 1'b0, 2'd0, 1'b1, 16'h0118, 16'h00BC, 3'd2, 1'b0};
    vecs[12] = '{16'h0ABC, 3'd3, 1'b0, 2'd1, 1'b1, 16'h011A, 16'h00BC, 3'd5, 1'b0};
    vecs[13] = '{16'h0ABC, 3'd3, 1'b0, 2'd2, 1'b1, 16'h011C, 16'h00BC, 3'd7, 1'b0};
    vecs[14] = '{16'h0ABC, 3'd3, 1'b0, 2'd3, 1'b1, 16'h011E, 16'h00BC, 3'd7, 1'b0};

    rst = 1'b1; instrIn = '0; instrValid = 1'b0; pcIn = '0; regWriteIn = 1'b0;
    dstSel = '0; immFmt = '0; wbWrite = 1'b0; wbReg = '0; wbData = '0;
    stall = 1'b0; flush = 1'b0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;

    // Dirty every register and raise Err, so the reset that follows has real work to do.
    for (int i = 0; i < 8; i++) begin
      wbWrite = 1'b1; wbReg = 3'(i); wbData = 16'h1000 + 16'(i);
      applyStimulus();
    end
    wbWrite = 1'b0;
    instrIn = 16'hF8F0; instrValid = 1'b1; immFmt = 3'd6; pcIn = 16'h0042; regWriteIn = 1'b1;
    applyStimulus();
    checkOutput("preResetErr", 32'(err1), 32'd1);
    checkOutput("preResetValid", 32'(valid1), 32'd1);

    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    instrValid = 1'b0; immFmt = 3'd0; regWriteIn = 1'b0; pcIn = '0;
    checkOutput("resetValid", 32'(valid1), 32'd0);
    checkOutput("resetErr", 32'(err1), 32'd0);
    checkOutput("resetRw", 32'(rw1), 32'd0);
    checkOutput("resetPc", 32'(pc1), 32'd0);
    checkOutput("resetErrNoByp", 32'(err0), 32'd0);

    // Every register must read zero after reset.
    for (int i = 0; i < 8; i++) begin
      instrIn = 16'((i << 8) | (i << 5));
      applyStimulus();
      checkOutput($sformatf("resetReg%0d_op1", i), 32'(opA1), 32'd0);
      checkOutput($sformatf("resetReg%0d_op2", i), 32'(opB1), 32'd0);
      checkOutput($sformatf("resetReg%0d_op1_nobyp", i), 32'(opA0), 32'd0);
    end

    // Writeback to r3 in the same cycle as decoding Rs = 3.
    instrIn = 16'h0300; instrValid = 1'b1;
    wbWrite = 1'b1; wbReg = 3'd3; wbData = 16'h1234;
    applyStimulus();
    wbWrite = 1'b0;
    checkOutput("bypassOp1", 32'(opA1), 32'h1234);
    checkOutput("noBypassOp1", 32'(opA0), 32'h0000);
    applyStimulus();
    checkOutput("redecodeOp1", 32'(opA1), 32'h1234);
    checkOutput("redecodeOp1NoByp", 32'(opA0), 32'h1234);

    // Table-driven immediate and destination checks.
    for (int k = 0; k < 15; k++) begin
      instrIn = vecs[k].instr; immFmt = vecs[k].fmt; instrValid = vecs[k].valid;
      dstSel = vecs[k].dSel; regWriteIn = vecs[k].regWr; pcIn = vecs[k].pc;
      applyStimulus();
      checkOutput($sformatf("vec%0d_imm", k), 32'(imm1), 32'(vecs[k].expImm));
      checkOutput($sformatf("vec%0d_dst", k), 32'(dst1), 32'(vecs[k].expDst));
      checkOutput($sformatf("vec%0d_rw", k), 32'(rw1), 32'(vecs[k].expRw));
      checkOutput($sformatf("vec%0d_valid", k), 32'(valid1), 32'(vecs[k].valid));
      checkOutput($sformatf("vec%0d_pc", k), 32'(pc1), 32'(vecs[k].pc));
    end
    checkOutput("errAfterTable", 32'(err1), 32'd0);

    // An illegal format does not set Err when the instruction is invalid, stalled or flushed.
    instrIn = 16'hF8F0; immFmt = 3'd7; instrValid = 1'b0; dstSel = 2'd0; regWriteIn = 1'b0;
    applyStimulus();
    checkOutput("fmt7Imm", 32'(imm1), 32'd0);
    checkOutput("errInvalid", 32'(err1), 32'd0);
    immFmt = 3'd6; instrValid = 1'b1; stall = 1'b1;
    applyStimulus();
    checkOutput("errStalled", 32'(err1), 32'd0);
    stall = 1'b0; flush = 1'b1;
    applyStimulus();
    checkOutput("errFlushed", 32'(err1), 32'd0);
    flush = 1'b0;
    immFmt = 3'd3;
    applyStimulus();
    checkOutput("preIllegalImm", 32'(imm1), 32'h00F0);
    immFmt = 3'd6;
    applyStimulus();
    checkOutput("fmt6Imm", 32'(imm1), 32'd0);
    checkOutput("fmt6Err", 32'(err1), 32'd1);
    immFmt = 3'd0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      checkOutput($sformatf("errSticky%0d", c), 32'(err1), 32'd1);
    end

    // Stall refresh: capture Rt = 5, then write r5 in the second stalled cycle.
    instrValid = 1'b0; wbWrite = 1'b1; wbReg = 3'd5; wbData = 16'h0001;
    applyStimulus();
    wbWrite = 1'b0;
    instrIn = 16'h00A0; instrValid = 1'b1; regWriteIn = 1'b1; dstSel = 2'd1;
    immFmt = 3'd3; pcIn = 16'h0200;
    applyStimulus();
    checkOutput("stallCaptureOp2", 32'(opB1), 32'h0001);
    checkOutput("stallCaptureOp2NoByp", 32'(opB0), 32'h0001);
    stall = 1'b1;
    instrIn = 16'hFFFF; instrValid = 1'b0; regWriteIn = 1'b0; dstSel = 2'd0;
    immFmt = 3'd4; pcIn = 16'hEEEE;
    applyStimulus();
    checkHeld(1, 16'h0001, 16'h0001);
    wbWrite = 1'b1; wbReg = 3'd5; wbData = 16'hBEEF;
    applyStimulus();
    wbWrite = 1'b0;
    checkHeld(2, 16'hBEEF, 16'h0001);
    applyStimulus();
    checkHeld(3, 16'hBEEF, 16'h0001);

    // Flush beats stall; afterwards the next instruction is captured in one cycle.
    flush = 1'b1;
    applyStimulus();
    checkOutput("flushStallValid", 32'(valid1), 32'd0);
    checkOutput("flushStallRw", 32'(rw1), 32'd0);
    checkOutput("flushStallValidNoByp", 32'(valid0), 32'd0);
    stall = 1'b0; flush = 1'b0;
    instrIn = 16'h0ABC; instrValid = 1'b1; regWriteIn = 1'b1; dstSel = 2'd2;
    immFmt = 3'd1; pcIn = 16'h0300;
    applyStimulus();
    checkOutput("postFlushValid", 32'(valid1), 32'd1);
    checkOutput("postFlushRw", 32'(rw1), 32'd1);
    checkOutput("postFlushDst", 32'(dst1), 32'd7);
    checkOutput("postFlushPc", 32'(pc1), 32'h0300);
    checkOutput("postFlushImm", 32'(imm1), 32'h001C);
    checkOutput("postFlushOp1", 32'(opA1), 32'h0000);
    checkOutput("postFlushOp2", 32'(opB1), 32'hBEEF);
    checkOutput("postFlushOp2NoByp", 32'(opB0), 32'hBEEF);
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    checkOutput("flushOnlyValid", 32'(valid1), 32'd0);
    checkOutput("flushOnlyRw", 32'(rw1), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
